// File: rtl/xgriscv_lsu.sv
// Load/store unit driving the byte-addressed dmem port. Misaligned accesses are
// optionally split into byte beats and reassembled before sign/zero extension.
//
// state    | meaning
// S_IDLE   | ready for a request; dmem idle drive
// S_SINGLE | one aligned dmem access in flight
// S_SPLIT  | byte beats, beat_q = index of current byte
// S_RESP   | response registers valid for one cycle
module xgriscv_lsu #(
    parameter int XLEN       = 32,
    parameter int DMEM_BYTES = 4096,
    parameter int SPLIT_EN   = 1
) (
    input  logic            clk_i,
    input  logic            rst_n,
    input  logic            req_valid_i,
    output logic            req_ready_o,
    input  logic            req_we_i,
    input  logic [1:0]      req_size_i,
    input  logic            req_unsigned_i,
    input  logic [XLEN-1:0] req_addr_i,
    input  logic [XLEN-1:0] req_wdata_i,
    output logic            resp_valid_o,
    output logic [XLEN-1:0] resp_rdata_o,
    output logic            resp_err_o,
    output logic            resp_misaligned_o,
    output logic            mem_we_o,
    output logic [XLEN-1:0] mem_a_o,
    output logic [XLEN-1:0] mem_wd_o,
    output logic [1:0]      mem_lwhb_o,
    output logic [1:0]      mem_swhb_o,
    output logic            mem_lu_o,
    input  logic [XLEN-1:0] mem_rd_i
);

    typedef enum logic [1:0] {S_IDLE, S_SINGLE, S_SPLIT, S_RESP} state_t;

    state_t          state_q, state_d;
    logic            we_q, we_d, uns_q, uns_d;
    logic [1:0]      size_q, size_d, beat_q, beat_d;
    logic [XLEN-1:0] addr_q, addr_d, wdata_q, wdata_d, buf_q, buf_d;
    logic            rvalid_q, rvalid_d, rerr_q, rerr_d, rmis_q, rmis_d;
    logic [XLEN-1:0] rdata_q, rdata_d;

    logic [2:0]      req_nbytes, cur_nbytes;
    logic [XLEN:0]   req_end;
    logic            req_bad, req_mis, last_beat;
    logic [XLEN-1:0] split_ins, wshift;

    function automatic logic [XLEN-1:0] extend(input logic [XLEN-1:0] d,
                                               input logic [1:0] sz, input logic uns);
        case (sz)
            2'b01:   extend = uns ? {{(XLEN-8){1'b0}}, d[7:0]}   : {{(XLEN-8){d[7]}}, d[7:0]};
            2'b10:   extend = uns ? {{(XLEN-16){1'b0}}, d[15:0]} : {{(XLEN-16){d[15]}}, d[15:0]};
            default: extend = d;
        endcase
    endfunction

    function automatic logic [2:0] nbytes_of(input logic [1:0] sz);
        case (sz)
            2'b11:   nbytes_of = 3'd4;
            2'b10:   nbytes_of = 3'd2;
            default: nbytes_of = 3'd1;
        endcase
    endfunction

    // End address in XLEN+1 bits so a request near the top of the space cannot wrap into range.
    assign req_nbytes = nbytes_of(req_size_i);
    assign req_end    = {1'b0, req_addr_i} + {{(XLEN-2){1'b0}}, req_nbytes} - (XLEN+1)'(1);
    assign req_mis    = (req_size_i == 2'b11 && req_addr_i[1:0] != 2'b00) ||
                        (req_size_i == 2'b10 && req_addr_i[0]);
    assign req_bad    = (req_size_i == 2'b00) || (req_end >= (XLEN+1)'(DMEM_BYTES)) ||
                        (req_mis && SPLIT_EN == 0);

    assign cur_nbytes = nbytes_of(size_q);
    assign last_beat  = ({1'b0, beat_q} == cur_nbytes - 3'd1);
    assign split_ins  = XLEN'(mem_rd_i[7:0]) << {beat_q, 3'b000};
    assign wshift     = wdata_q >> {beat_q, 3'b000};

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            we_q     <= 1'b0;
            uns_q    <= 1'b0;
            size_q   <= 2'b00;
            beat_q   <= 2'b00;
            addr_q   <= '0;
            wdata_q  <= '0;
            buf_q    <= '0;
            rvalid_q <= 1'b0;
            rerr_q   <= 1'b0;
            rmis_q   <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            we_q     <= we_d;
            uns_q    <= uns_d;
            size_q   <= size_d;
            beat_q   <= beat_d;
            addr_q   <= addr_d;
            wdata_q  <= wdata_d;
            buf_q    <= buf_d;
            rvalid_q <= rvalid_d;
            rerr_q   <= rerr_d;
            rmis_q   <= rmis_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        we_d     = we_q;
        uns_d    = uns_q;
        size_d   = size_q;
        beat_d   = beat_q;
        addr_d   = addr_q;
        wdata_d  = wdata_q;
        buf_d    = buf_q;
        rvalid_d = 1'b0;
        rerr_d   = 1'b0;
        rmis_d   = 1'b0;
        rdata_d  = '0;
        case (state_q)
            S_IDLE: begin
                if (req_valid_i) begin
                    we_d    = req_we_i;
                    uns_d   = req_unsigned_i;
                    size_d  = req_size_i;
                    addr_d  = req_addr_i;
                    wdata_d = req_wdata_i;
                    beat_d  = 2'b00;
                    buf_d   = '0;
                    if (req_bad) begin
                        state_d  = S_RESP;
                        rvalid_d = 1'b1;
                        rerr_d   = 1'b1;
                    end else if (req_mis) begin
                        state_d = S_SPLIT;
                    end else begin
                        state_d = S_SINGLE;
                    end
                end
            end
            S_SINGLE: begin
                state_d  = S_RESP;
                rvalid_d = 1'b1;
                rdata_d  = we_q ? '0 : extend(mem_rd_i, size_q, uns_q);
            end
            S_SPLIT: begin
                buf_d  = buf_q | split_ins;
                beat_d = beat_q + 2'd1;
                if (last_beat) begin
                    state_d  = S_RESP;
                    rvalid_d = 1'b1;
                    rmis_d   = 1'b1;
                    rdata_d  = we_q ? '0 : extend(buf_q | split_ins, size_q, uns_q);
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        mem_we_o   = 1'b0;
        mem_a_o    = '0;
        mem_wd_o   = '0;
        mem_lwhb_o = 2'b11;
        mem_swhb_o = 2'b00;
        mem_lu_o   = 1'b0;
        if (state_q == S_SINGLE) begin
            mem_a_o    = addr_q;
            mem_lwhb_o = size_q;
            mem_lu_o   = uns_q;
            if (we_q) begin
                mem_we_o   = 1'b1;
                mem_swhb_o = size_q;
                mem_wd_o   = wdata_q;
            end
        end else if (state_q == S_SPLIT) begin
            mem_a_o    = addr_q + XLEN'(beat_q);
            mem_lwhb_o = 2'b01;
            mem_swhb_o = 2'b01;
            mem_lu_o   = 1'b1;
            if (we_q) begin
                mem_we_o = 1'b1;
                mem_wd_o = {{(XLEN-8){1'b0}}, wshift[7:0]};
            end
        end
    end

    assign req_ready_o       = (state_q == S_IDLE);
    assign resp_valid_o      = rvalid_q;
    assign resp_rdata_o      = rdata_q;
    assign resp_err_o        = rerr_q;
    assign resp_misaligned_o = rmis_q;

endmodule

// File: tb/tb_xgriscv_lsu.sv
// Bench for xgriscv_lsu: byte-array dmem model, scoreboard of expected responses,
// and a second instance built with splitting disabled.
module tb_xgriscv_lsu;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_we = 1'b0, req_uns = 1'b0;
    logic [1:0]  req_size = 2'b00;
    logic [31:0] req_addr = '0, req_wdata = '0;
    logic        valid_a = 1'b0, valid_b = 1'b0;

    logic        ready_a, rv_a, err_a, mis_a, we_a, lu_a;
    logic [31:0] rdata_a, a_a, wd_a, rd_a;
    logic [1:0]  lwhb_a, swhb_a;
    logic        ready_b, rv_b, err_b, mis_b, we_b, lu_b;
    logic [31:0] rdata_b, a_b, wd_b;
    logic [31:0] rd_b = '0;
    logic [1:0]  lwhb_b, swhb_b;

    always #5 clk = ~clk;

    xgriscv_lsu #(.XLEN(32), .DMEM_BYTES(4096), .SPLIT_EN(1)) dut_a (
        .clk_i(clk), .rst_n(rst_n), .req_valid_i(valid_a), .req_ready_o(ready_a),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .resp_valid_o(rv_a),
        .resp_rdata_o(rdata_a), .resp_err_o(err_a), .resp_misaligned_o(mis_a),
        .mem_we_o(we_a), .mem_a_o(a_a), .mem_wd_o(wd_a), .mem_lwhb_o(lwhb_a),
        .mem_swhb_o(swhb_a), .mem_lu_o(lu_a), .mem_rd_i(rd_a));

    xgriscv_lsu #(.XLEN(32), .DMEM_BYTES(4096), .SPLIT_EN(0)) dut_b (
        .clk_i(clk), .rst_n(rst_n), .req_valid_i(valid_b), .req_ready_o(ready_b),
        .req_we_i(req_we), .req_size_i(req_size), .req_unsigned_i(req_uns),
        .req_addr_i(req_addr), .req_wdata_i(req_wdata), .resp_valid_o(rv_b),
        .resp_rdata_o(rdata_b), .resp_err_o(err_b), .resp_misaligned_o(mis_b),
        .mem_we_o(we_b), .mem_a_o(a_b), .mem_wd_o(wd_b), .mem_lwhb_o(lwhb_b),
        .mem_swhb_o(swhb_b), .mem_lu_o(lu_b), .mem_rd_i(rd_b));

    // dmem model: combinational read with width/extension, byte-enabled write on the edge
    logic [7:0]  dmem [0:4095];
    logic [7:0]  shadow [0:4095];
    logic [11:0] ai;
    logic [7:0]  b0, b1, b2, b3;
    always_comb begin
        ai = a_a[11:0];
        b0 = dmem[ai];
        b1 = dmem[ai + 12'd1];
        b2 = dmem[ai + 12'd2];
        b3 = dmem[ai + 12'd3];
        case (lwhb_a)
            2'b01:   rd_a = lu_a ? {24'h0, b0} : {{24{b0[7]}}, b0};
            2'b10:   rd_a = lu_a ? {16'h0, b1, b0} : {{16{b1[7]}}, b1, b0};
            default: rd_a = {b3, b2, b1, b0};
        endcase
    end

    logic [19:0] wlog [$];
    int          we_b_cnt = 0;
    int          rv_cnt = 0;
    always @(posedge clk) begin
        if (we_a) begin
            wlog.push_back({a_a[11:0], wd_a[7:0]});
            dmem[a_a[11:0]] <= wd_a[7:0];
            if (swhb_a == 2'b10 || swhb_a == 2'b11) dmem[a_a[11:0] + 12'd1] <= wd_a[15:8];
            if (swhb_a == 2'b11) begin
                dmem[a_a[11:0] + 12'd2] <= wd_a[23:16];
                dmem[a_a[11:0] + 12'd3] <= wd_a[31:24];
            end
        end
        if (we_b) we_b_cnt++;
        if (rv_a) rv_cnt++;
    end

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        logic        mis;
        int          lat;
    } resp_t;

    resp_t sb [$];
    int    n_cmp = 0;
    int    n_fail = 0;

    task automatic do_req(input bit sel, input logic we, input logic [1:0] size,
                          input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                          output resp_t obs);
        bit accepted;
        obs.rdata = 'x; obs.err = 1'bx; obs.mis = 1'bx; obs.lat = -1;
        accepted = 0;
        @(negedge clk);
        req_we = we; req_size = size; req_uns = uns; req_addr = addr; req_wdata = wdata;
        for (int t = 0; t < 20 && !accepted; t++) begin
            if ((sel ? ready_b : ready_a) === 1'b1) begin
                if (sel) valid_b = 1'b1; else valid_a = 1'b1;
                accepted = 1;
            end else @(negedge clk);
        end
        if (!accepted) return;
        @(posedge clk); #1;
        valid_a = 1'b0; valid_b = 1'b0;
        for (int c = 1; c <= 20; c++) begin
            if ((sel ? rv_b : rv_a) === 1'b1) begin
                obs.rdata = sel ? rdata_b : rdata_a;
                obs.err   = sel ? err_b : err_a;
                obs.mis   = sel ? mis_b : mis_a;
                obs.lat   = c;
                break;
            end
            @(posedge clk); #1;
        end
        @(posedge clk); #1;
    endtask

    function automatic logic [31:0] model_load(input logic [31:0] addr, input logic [1:0] size,
                                               input logic uns);
        int nb;
        logic [31:0] v;
        nb = (size == 2'b11) ? 4 : (size == 2'b10) ? 2 : 1;
        v = '0;
        for (int k = 0; k < nb; k++) v[8*k +: 8] = shadow[addr[11:0] + 12'(k)];
        if (!uns && v[8*nb-1]) for (int k = 8*nb; k < 32; k++) v[k] = 1'b1;
        return v;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #3;
        n_cmp++;
        if ({ready_a, rv_a, err_a, mis_a, we_a, lwhb_a, swhb_a, lu_a} !== 10'b1000_0110_00 ||
            rdata_a !== 32'h0 || a_a !== 32'h0 || wd_a !== 32'h0) begin
            n_fail++;
            $display("FAIL reset_state: ready=%b rv=%b err=%b mis=%b we=%b lwhb=%b swhb=%b lu=%b rdata=%h a=%h wd=%h, want ready=1 lwhb=11 others 0",
                     ready_a, rv_a, err_a, mis_a, we_a, lwhb_a, swhb_a, lu_a, rdata_a, a_a, wd_a);
        end
        @(negedge clk); rst_n = 1'b1;
        @(negedge clk);
    endtask

    task automatic test_aligned_load();
        resp_t o, e;
        dmem[16] = 8'h78; dmem[17] = 8'h56; dmem[18] = 8'h34; dmem[19] = 8'h12;
        sb.push_back('{32'h12345678, 1'b0, 1'b0, 2});
        do_req(0, 1'b0, 2'b11, 1'b0, 32'h10, 32'h0, o);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL word_load: got rdata=%h err=%b mis=%b lat=%0d, want %h %b %b %0d",
                     o.rdata, o.err, o.mis, o.lat, e.rdata, e.err, e.mis, e.lat);
        end
    endtask

    task automatic test_byte_loads();
        resp_t o, e;
        dmem[33] = 8'h80;
        sb.push_back('{32'hFFFFFF80, 1'b0, 1'b0, 2});
        sb.push_back('{32'h00000080, 1'b0, 1'b0, 2});
        for (int u = 0; u < 2; u++) begin
            do_req(0, 1'b0, 2'b01, u[0], 32'h21, 32'h0, o);
            e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL byte_load uns=%0d: got rdata=%h err=%b mis=%b lat=%0d, want %h %b %b %0d",
                         u, o.rdata, o.err, o.mis, o.lat, e.rdata, e.err, e.mis, e.lat);
            end
        end
    endtask

    task automatic test_split_store();
        resp_t o, e;
        logic [31:0] wd;
        logic [19:0] ent;
        wd = 32'hAABBCCDD;
        wlog.delete();
        sb.push_back('{32'h0, 1'b0, 1'b1, 5});
        do_req(0, 1'b1, 2'b11, 1'b0, 32'h3, wd, o);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL split_store_resp: got rdata=%h err=%b mis=%b lat=%0d, want %h %b %b %0d",
                     o.rdata, o.err, o.mis, o.lat, e.rdata, e.err, e.mis, e.lat);
        end
        n_cmp++;
        if (wlog.size() != 4) begin
            n_fail++;
            $display("FAIL split_store_beats: got %0d write beats, want 4", wlog.size());
        end
        for (int i = 0; i < 4 && i < wlog.size(); i++) begin
            ent = {12'(3 + i), wd[8*i +: 8]};
            n_cmp++;
            if (wlog[i] !== ent) begin
                n_fail++;
                $display("FAIL split_store_beat%0d: got a=%h wd=%h, want a=%h wd=%h",
                         i, wlog[i][19:8], wlog[i][7:0], ent[19:8], ent[7:0]);
            end
        end
    endtask

    task automatic test_split_half_load();
        resp_t o, e;
        dmem[7] = 8'h34; dmem[8] = 8'h92;
        sb.push_back('{32'hFFFF9234, 1'b0, 1'b1, 3});
        sb.push_back('{32'h00009234, 1'b0, 1'b1, 3});
        for (int u = 0; u < 2; u++) begin
            do_req(0, 1'b0, 2'b10, u[0], 32'h7, 32'h0, o);
            e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL split_half_load uns=%0d: got rdata=%h err=%b mis=%b lat=%0d, want %h %b %b %0d",
                         u, o.rdata, o.err, o.mis, o.lat, e.rdata, e.err, e.mis, e.lat);
            end
        end
    endtask

    task automatic test_errors();
        resp_t o, e;
        int    wb0;
        wlog.delete();
        sb.push_back('{32'h0, 1'b1, 1'b0, 1});
        do_req(0, 1'b1, 2'b11, 1'b0, 32'hFFE, 32'h01020304, o);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e || wlog.size() != 0) begin
            n_fail++;
            $display("FAIL err_range: got rdata=%h err=%b mis=%b lat=%0d writes=%0d, want %h %b %b %0d writes=0",
                     o.rdata, o.err, o.mis, o.lat, wlog.size(), e.rdata, e.err, e.mis, e.lat);
        end
        sb.push_back('{32'h0, 1'b1, 1'b0, 1});
        do_req(0, 1'b0, 2'b00, 1'b0, 32'h10, 32'h0, o);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL err_size0: got rdata=%h err=%b mis=%b lat=%0d, want %h %b %b %0d",
                     o.rdata, o.err, o.mis, o.lat, e.rdata, e.err, e.mis, e.lat);
        end
        // last legal half-word must still be accepted
        dmem[4094] = 8'hEF; dmem[4095] = 8'hBE;
        sb.push_back('{32'h0000BEEF, 1'b0, 1'b0, 2});
        do_req(0, 1'b0, 2'b10, 1'b1, 32'hFFE, 32'h0, o);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e) begin
            n_fail++;
            $display("FAIL edge_half_top: got rdata=%h err=%b mis=%b lat=%0d, want %h %b %b %0d",
                     o.rdata, o.err, o.mis, o.lat, e.rdata, e.err, e.mis, e.lat);
        end
        wb0 = we_b_cnt;
        sb.push_back('{32'h0, 1'b1, 1'b0, 1});
        do_req(1, 1'b1, 2'b10, 1'b0, 32'h1, 32'h5555, o);
        e = sb.pop_front();
        n_cmp++;
        if (o !== e || we_b_cnt != wb0) begin
            n_fail++;
            $display("FAIL err_nosplit: got rdata=%h err=%b mis=%b lat=%0d we_beats=%0d, want %h %b %b %0d we_beats=0",
                     o.rdata, o.err, o.mis, o.lat, we_b_cnt - wb0, e.rdata, e.err, e.mis, e.lat);
        end
    endtask

    task automatic test_back_to_back();
        resp_t o, e;
        logic [1:0]  sz;
        logic [31:0] ad, wd;
        logic        st, un;
        int          nb;
        bit          mis;
        for (int i = 256; i < 512; i++) begin
            dmem[i] = 8'($urandom);
            shadow[i] = dmem[i];
        end
        for (int k = 0; k < 16; k++) begin
            st = 1'($urandom_range(0, 1));
            un = 1'($urandom_range(0, 1));
            sz = 2'($urandom_range(1, 3));
            ad = 32'($urandom_range(256, 500));
            wd = $urandom;
            nb = (sz == 2'b11) ? 4 : (sz == 2'b10) ? 2 : 1;
            mis = (sz == 2'b11 && ad[1:0] != 2'b00) || (sz == 2'b10 && ad[0]);
            if (st) begin
                sb.push_back('{32'h0, 1'b0, mis, mis ? nb + 1 : 2});
                for (int b = 0; b < nb; b++) shadow[ad[11:0] + 12'(b)] = wd[8*b +: 8];
            end else begin
                sb.push_back('{model_load(ad, sz, un), 1'b0, mis, mis ? nb + 1 : 2});
            end
            do_req(0, st, sz, un, ad, wd, o);
            e = sb.pop_front();
            n_cmp++;
            if (o !== e) begin
                n_fail++;
                $display("FAIL b2b[%0d] we=%b size=%b addr=%h: got rdata=%h err=%b mis=%b lat=%0d, want %h %b %b %0d",
                         k, st, sz, ad, o.rdata, o.err, o.mis, o.lat, e.rdata, e.err, e.mis, e.lat);
            end
        end
    endtask

    task automatic test_reset_mid_split();
        int rv0;
        for (int i = 1; i <= 4; i++) dmem[i] = 8'h00;
        @(negedge clk);
        req_we = 1'b1; req_size = 2'b11; req_uns = 1'b0; req_addr = 32'h1; req_wdata = 32'h44332211;
        valid_a = 1'b1;
        @(posedge clk); #1;
        valid_a = 1'b0;
        rv0 = rv_cnt;
        @(posedge clk);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        n_cmp++;
        if (we_a !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_mid_we: got mem_we=%b, want 0", we_a);
        end
        repeat (2) @(posedge clk);
        @(negedge clk); rst_n = 1'b1;
        @(posedge clk); #1;
        n_cmp++;
        if (ready_a !== 1'b1 || rv_cnt != rv0) begin
            n_fail++;
            $display("FAIL rst_mid_state: got ready=%b resp_pulses=%0d, want ready=1 resp_pulses=0",
                     ready_a, rv_cnt - rv0);
        end
        n_cmp++;
        if ({dmem[1], dmem[2], dmem[3], dmem[4]} !== 32'h11220000) begin
            n_fail++;
            $display("FAIL rst_mid_mem: got dmem[1..4]=%h %h %h %h, want 11 22 00 00",
                     dmem[1], dmem[2], dmem[3], dmem[4]);
        end
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) begin
            dmem[i] = 8'h00;
            shadow[i] = 8'h00;
        end
        test_reset();
        test_aligned_load();
        test_byte_loads();
        test_split_store();
        test_split_half_load();
        test_errors();
        test_back_to_back();
        test_reset_mid_split();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
